// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants and types for the HI/LO multiply/divide unit.
// Forwarding on the read ports is enabled by defining HILO_FWD_EN.
package hilo_pkg;

  localparam int DW_DEF = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/hilo_if.sv
// hilo_if: operation launch, direct HI/LO writes and gated reads.
// master = pipeline side, slave = hilo_mdu (HILO_FWD_EN affects slave only).
interface hilo_if
  import hilo_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic          flush;
  logic          hi_we;
  logic          lo_we;
  logic [DW-1:0] hi_i;
  logic [DW-1:0] lo_i;
  logic          hi_re;
  logic          lo_re;
  logic          busy;
  logic          done;
  logic          div0;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;

  modport master (
    output start, op, src_a, src_b, flush,
    output hi_we, lo_we, hi_i, lo_i,
    output hi_re, lo_re,
    input  busy, done, div0, hi_o, lo_o
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    input  hi_we, lo_we, hi_i, lo_i,
    input  hi_re, lo_re,
    output busy, done, div0, hi_o, lo_o
  );

endinterface

// File: rtl/hilo_regfile.sv
// hilo_regfile: HI/LO pair, direct writes beat the MDU result.
// With HILO_FWD_EN the read ports show the value being written this cycle.
module hilo_regfile #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hi_we,
  input  logic          lo_we,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  input  logic          res_we,
  input  logic [DW-1:0] res_hi,
  input  logic [DW-1:0] res_lo,
  input  logic          hi_re,
  input  logic          lo_re,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] hi_v, lo_v;

  // next value: younger direct write first, then the MDU result
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hi_we)       hi_d = hi_i;
    else if (res_we) hi_d = res_hi;
    if (lo_we)       lo_d = lo_i;
    else if (res_we) lo_d = res_lo;
  end

  // register update
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // read data: forwarded or registered, gated by the read enables
  always_comb begin
`ifdef HILO_FWD_EN
    hi_v = hi_d;
    lo_v = lo_d;
`else
    hi_v = hi_q;
    lo_v = lo_q;
`endif
    hi_o = hi_re ? hi_v : '0;
    lo_o = lo_re ? lo_v : '0;
  end

endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO registers with an iterative DW-step multiply/divide.
// Define HILO_FWD_EN to forward same-cycle writes onto hi_o/lo_o.
module hilo_mdu
  import hilo_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input logic   clk,
  input logic   rst,
  hilo_if.slave bus
);

  localparam int CW = $clog2(DW);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   m_q, m_d;
  logic [2*DW-1:0] p_q, p_d;
  logic            dv_q, dv_d;
  logic            na_q, na_d;
  logic            nb_q, nb_d;
  logic            z_q, z_d;

  logic            is_div;
  logic            sgn;
  logic            neg_a;
  logic            neg_b;
  logic [DW-1:0]   abs_a;
  logic [DW-1:0]   abs_b;
  logic [DW:0]     sum;
  logic [2*DW-1:0] mul_nxt;
  logic [DW:0]     shrem;
  logic [DW:0]     diff;
  logic            qbit;
  logic [DW-1:0]   rem;
  logic [2*DW-1:0] div_nxt;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   quo_s;
  logic [DW-1:0]   rem_s;
  logic            res_we;
  logic [DW-1:0]   res_hi;
  logic [DW-1:0]   res_lo;

  // operand decode and magnitude extraction
  always_comb begin
    is_div = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    sgn    = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    neg_a  = sgn & bus.src_a[DW-1];
    neg_b  = sgn & bus.src_b[DW-1];
    abs_a  = neg_a ? -bus.src_a : bus.src_a;
    abs_b  = neg_b ? -bus.src_b : bus.src_b;
  end

  // one shift-add / restoring-subtract step on {hi,lo}
  always_comb begin
    sum     = {1'b0, p_q[2*DW-1:DW]}
            + (p_q[0] ? {1'b0, m_q} : '0);
    mul_nxt = {sum, p_q[DW-1:1]};
    shrem   = {p_q[2*DW-1:DW], p_q[DW-1]};
    diff    = shrem - {1'b0, m_q};
    qbit    = ~diff[DW];
    rem     = qbit ? diff[DW-1:0] : shrem[DW-1:0];
    div_nxt = {rem, p_q[DW-2:0], qbit};
  end

  // sign correction of the finished magnitudes
  always_comb begin
    prod   = (na_q ^ nb_q) ? -p_q : p_q;
    quo_s  = (na_q ^ nb_q) ? -p_q[DW-1:0] : p_q[DW-1:0];
    rem_s  = na_q ? -p_q[2*DW-1:DW] : p_q[2*DW-1:DW];
    res_hi = dv_q ? rem_s : prod[2*DW-1:DW];
    res_lo = dv_q ? quo_s : prod[DW-1:0];
  end

  // next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    p_d     = p_q;
    dv_d    = dv_q;
    na_d    = na_q;
    nb_d    = nb_q;
    z_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (is_div && bus.src_b == '0) begin
            z_d = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            dv_d    = is_div;
            na_d    = neg_a;
            nb_d    = neg_b;
            m_d     = is_div ? abs_b : abs_a;
            p_d     = {{DW{1'b0}},
                       is_div ? abs_a : abs_b};
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          p_d   = dv_q ? div_nxt : mul_nxt;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1))
            state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // control outputs
  always_comb begin
    res_we   = (state_q == FIX) && !bus.flush;
    bus.busy = (state_q != IDLE);
    bus.done = res_we | z_q;
    bus.div0 = z_q;
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      dv_q    <= 1'b0;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_q     <= p_d;
      dv_q    <= dv_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      z_q     <= z_d;
    end
  end

  hilo_regfile #(.DW(DW)) u_regs (
    .clk    (clk),
    .rst    (rst),
    .hi_we  (bus.hi_we),
    .lo_we  (bus.lo_we),
    .hi_i   (bus.hi_i),
    .lo_i   (bus.lo_i),
    .res_we (res_we),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .hi_re  (bus.hi_re),
    .lo_re  (bus.lo_re),
    .hi_o   (bus.hi_o),
    .lo_o   (bus.lo_o)
  );

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed checks of hilo_mdu at DW=32.
// Expectations for the done-cycle read depend on HILO_FWD_EN.
module tb_hilo_mdu;
  import hilo_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  hilo_if #(.DW(32)) bus ();

  hilo_mdu #(.DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n,
                           output int nb, output bit to);
    n  = n0;
    nb = 0;
    to = 1'b0;
    while (bus.done !== 1'b1) begin
      if (bus.busy === 1'b1) nb++;
      if (n >= 200) begin
        to = 1'b1;
        break;
      end
      step();
      n++;
    end
    if (bus.busy === 1'b1) nb++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.div0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b/%b exp=0/0",
               bus.done, bus.div0);
    end
    checks++;
    if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo got=%h/%h exp=0/0",
               bus.hi_o, bus.lo_o);
    end
  endtask

  task automatic test_mult();
    int n, nb;
    bit to;
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(1, n, nb, to);
    checks++;
    if (to || n != 33) begin
      errors++;
      $display("FAIL mult_done_cycle got=T+%0d exp=T+33", n);
    end
    checks++;
    if (nb != 33) begin
      errors++;
      $display("FAIL mult_busy_len got=%0d exp=33", nb);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_busy_after got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_result got=%h_%h exp=ffffffff_fffffff1",
               bus.hi_o, bus.lo_o);
    end
  endtask

  task automatic test_multu();
    int n, nb;
    bit to;
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, n, nb, to);
    step();
    checks++;
    if (to || bus.hi_o !== 32'hFFFF_FFFE || bus.lo_o !== 32'h1) begin
      errors++;
      $display("FAIL multu_result got=%h_%h exp=fffffffe_00000001",
               bus.hi_o, bus.lo_o);
    end
  endtask

  task automatic test_div();
    int n, nb;
    bit to;
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(1, n, nb, to);
    step();
    checks++;
    if (to || bus.lo_o !== 32'hE || bus.hi_o !== 32'h2) begin
      errors++;
      $display("FAIL divu_result got=hi %h lo %h exp=hi 2 lo e",
               bus.hi_o, bus.lo_o);
    end
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, n, nb, to);
    checks++;
    if (to || n != 33) begin
      errors++;
      $display("FAIL div_done_cycle got=T+%0d exp=T+33", n);
    end
    step();
    checks++;
    if (bus.lo_o !== 32'hFFFF_FFFD || bus.hi_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_signed got=hi %h lo %h exp=hi ffffffff lo fffffffd",
               bus.hi_o, bus.lo_o);
    end
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, n, nb, to);
    step();
    checks++;
    if (to || bus.lo_o !== 32'h8000_0000 || bus.hi_o !== 32'h0) begin
      errors++;
      $display("FAIL div_overflow got=hi %h lo %h exp=hi 0 lo 80000000",
               bus.hi_o, bus.lo_o);
    end
  endtask

  task automatic test_div0();
    bit seen_busy;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.hi_i  = 32'h1234_5678;
    bus.lo_i  = 32'h9ABC_DEF0;
    step();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    launch(OP_DIV, 32'd5, 32'd0);
    seen_busy = bus.busy;
    checks++;
    if (bus.done !== 1'b1 || bus.div0 !== 1'b1) begin
      errors++;
      $display("FAIL div0_pulse got=done %b div0 %b exp=1/1",
               bus.done, bus.div0);
    end
    step();
    seen_busy = seen_busy | bus.busy;
    checks++;
    if (bus.done !== 1'b0 || bus.div0 !== 1'b0 || seen_busy) begin
      errors++;
      $display("FAIL div0_after got=done %b div0 %b busy %b exp=0/0/0",
               bus.done, bus.div0, seen_busy);
    end
    checks++;
    if (bus.hi_o !== 32'h1234_5678 || bus.lo_o !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL div0_hilo got=%h_%h exp=12345678_9abcdef0",
               bus.hi_o, bus.lo_o);
    end
  endtask

  task automatic test_flush();
    int ndone;
    do_reset();
    bus.hi_we = 1'b1;
    bus.hi_i  = 32'h1111_1111;
    step();
    bus.hi_we = 1'b0;
    launch(OP_MULT, 32'd2, 32'd3);
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy got=%b exp=0 at T+11", bus.busy);
    end
    ndone = 0;
    repeat (40) begin
      if (bus.done === 1'b1) ndone++;
      step();
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL flush_done got=%0d pulses exp=0", ndone);
    end
    checks++;
    if (bus.hi_o !== 32'h1111_1111 || bus.lo_o !== 32'h0) begin
      errors++;
      $display("FAIL flush_hilo got=%h_%h exp=11111111_00000000",
               bus.hi_o, bus.lo_o);
    end
  endtask

  task automatic test_wr_collision();
    int n, nb;
    bit to;
    launch(OP_MULT, 32'd2, 32'd3);
    wait_done(1, n, nb, to);
    bus.hi_we = 1'b1;
    bus.hi_i  = 32'hAAAA_AAAA;
    #1;
`ifdef HILO_FWD_EN
    checks++;
    if (to || bus.hi_o !== 32'hAAAA_AAAA || bus.lo_o !== 32'h6) begin
      errors++;
      $display("FAIL fwd_done_cycle got=%h_%h exp=aaaaaaaa_00000006",
               bus.hi_o, bus.lo_o);
    end
`else
    checks++;
    if (to || bus.hi_o !== 32'h1111_1111 || bus.lo_o !== 32'h0) begin
      errors++;
      $display("FAIL nofwd_done_cycle got=%h_%h exp=11111111_00000000",
               bus.hi_o, bus.lo_o);
    end
`endif
    step();
    bus.hi_we = 1'b0;
    checks++;
    if (bus.hi_o !== 32'hAAAA_AAAA || bus.lo_o !== 32'h6) begin
      errors++;
      $display("FAIL collide_hilo got=%h_%h exp=aaaaaaaa_00000006",
               bus.hi_o, bus.lo_o);
    end
    bus.hi_re = 1'b0;
    #1;
    checks++;
    if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h6) begin
      errors++;
      $display("FAIL read_gate got=%h_%h exp=00000000_00000006",
               bus.hi_o, bus.lo_o);
    end
    bus.hi_re = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n, nb;
    bit to;
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(1, n, nb, to);
    step();
    checks++;
    if (to || bus.lo_o !== 32'hE) begin
      errors++;
      $display("FAIL b2b_first got=lo %h exp=lo e", bus.lo_o);
    end
    launch(OP_MULTU, 32'd6, 32'd7);
    repeat (4) step();
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'd1;
    bus.src_b = 32'd1;
    step();
    bus.start = 1'b0;
    wait_done(6, n, nb, to);
    checks++;
    if (to || n != 33) begin
      errors++;
      $display("FAIL b2b_done_cycle got=T+%0d exp=T+33", n);
    end
    step();
    checks++;
    if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h2A) begin
      errors++;
      $display("FAIL b2b_result got=%h_%h exp=00000000_0000002a",
               bus.hi_o, bus.lo_o);
    end
  endtask

  task automatic test_rst_mid();
    int ndone;
    bus.lo_we = 1'b1;
    bus.lo_i  = 32'h1234_5678;
    step();
    bus.lo_we = 1'b0;
    launch(OP_MULTU, 32'd9, 32'd9);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.lo_o !== 32'h0 || bus.hi_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid got=busy %b %h_%h exp=0 0_0",
               bus.busy, bus.hi_o, bus.lo_o);
    end
    ndone = 0;
    repeat (40) begin
      if (bus.done === 1'b1) ndone++;
      step();
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL rst_mid_done got=%0d pulses exp=0", ndone);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MULTU;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.hi_i  = '0;
    bus.lo_i  = '0;
    bus.hi_re = 1'b1;
    bus.lo_re = 1'b1;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div0();
    test_flush();
    test_wr_collision();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Parametrised HI/LO register pair with an integrated iterative multiply/divide unit, for the EX/MEM stage of the CPU pipeline. Accepts MULT/MULTU/DIV/DIVU operations, computes them over DW+1 cycles with a busy/done handshake, and writes the 2·DW-bit result into HI/LO. Direct MTHI/MTLO-style writes and gated reads are kept. Optional forwarding makes same-cycle writes visible on the read ports.

## Interface
- DW, 32: data width of HI, LO and operands (≥4, even).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- src_a  in  DW  multiplicand / dividend.
- src_b  in  DW  multiplier / divisor.
- flush  in  1  abort in-flight operation, no HI/LO write.
- hi_we, lo_we  in  1 each  direct write enables.
- hi_i, lo_i  in  DW each  direct write data.
- hi_re, lo_re  in  1 each  read enables.
- busy  out  1  operation in progress; pipeline stalls on it.
- done  out  1  one-cycle pulse: result commits at the end of this cycle.
- div0  out  1  pulses with done when DIV/DIVU had src_b == 0.
- hi_o, lo_o  out  DW each  read data, 0 when the matching _re is low.

## Operation
- States: IDLE, CALC, FIX. Reset: IDLE, HI = LO = 0, busy = done = div0 = 0, iteration counter 0.
- IDLE + start: latch |src_a|, |src_b| (absolute values for signed ops), sign flags and op. Go to CALC with counter = 0.
- Exception: DIV/DIVU with src_b == 0 stays in IDLE. done and div0 pulse at T+1, and HI/LO are unchanged.
- CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle, for DW cycles. Then go to FIX.
- FIX: apply sign correction and assert done. At the cycle end write HI/LO and return to IDLE.
- Multiply result: {HI,LO} = full 2·DW-bit product. Signed ops use two's complement.
- Divide result: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- Quotient overflow (most-negative / −1): LO = most-negative, HI = 0.
- start outside IDLE is ignored.
- flush in CALC or FIX: return to IDLE next cycle, no write, no done. flush wins over start in IDLE.
- Direct writes apply in any state. If a direct write coincides with done on the same register, the direct write wins (it is the younger instruction). The other register takes the result.
- rst mid-operation: immediate IDLE, HI/LO cleared, no done.

## Timing
- start sampled at edge T. busy is high for cycles T+1 … T+DW+1. done is high in cycle T+DW+1. New HI/LO are visible from T+DW+2.
- A back-to-back start is accepted in the cycle after done (IDLE).
- Direct writes: registered, visible on the next cycle without forwarding.
- Reads: combinational from the registers, gated by _re.

## Configuration
- HILO_FWD_EN defined: hi_o/lo_o forward within the same cycle.
  - Forward hi_i/lo_i when the matching _we is high.
  - Otherwise forward the pending result when done is high.
  - Otherwise show the register.
  - _re gating still applies.
- HILO_FWD_EN undefined: hi_o/lo_o show register contents only. The pipeline must stall one cycle on a read-after-write.

## Structure
- Shared package hilo_pkg holds:
  - op encoding constants (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - state typedef (IDLE, CALC, FIX);
  - default DW.
- One sub-module, hilo_regfile: the HI/LO pair with per-register write enable, write-priority muxing (direct over result), and read gating/forwarding.
- The iteration datapath and FSM stay in hilo_mdu.

## Test plan
- MULT with −3 × 5 (DW=32) → done at T+33, HI = FFFFFFFF, LO = FFFFFFF1. busy is high for exactly 33 cycles.
- MULTU with FFFFFFFF × FFFFFFFF → HI = FFFFFFFE, LO = 00000001.
- DIVU 100 / 7 → LO = 0000000E, HI = 00000002.
- DIV −7 / 2 → LO = FFFFFFFD, HI = FFFFFFFF.
- DIV 5 / 0 → done and div0 at T+1, busy never high, HI/LO unchanged.
- Preload HI = 11111111 via hi_we, start MULT 2×3, flush at T+10 → no done, busy low at T+11, HI still 11111111, LO still 0.
- Start MULT 2×3, then pulse hi_we with AAAAAAAA in the done cycle → HI = AAAAAAAA, LO = 00000006.
  - With HILO_FWD_EN: hi_o = AAAAAAAA and lo_o = 00000006 during the done cycle.
  - Without HILO_FWD_EN: those values appear one cycle later.
